// File: rtl/wb_pkg.sv
// Shared constants, entry type and one-hot helper for the register writeback queue.
package wb_pkg;

    localparam int NREGS     = 8;
    localparam int DATA_W    = 8;
    localparam int REG_IDX_W = $clog2(NREGS);

    typedef struct packed {
        logic [REG_IDX_W-1:0] reg_idx;
        logic [DATA_W-1:0]    data;
    } wb_entry_t;

    function automatic logic [NREGS-1:0] onehot_reg(input logic [REG_IDX_W-1:0] idx);
        logic [NREGS-1:0] mask;
        mask      = {NREGS{1'b0}};
        mask[idx] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/wb_entry_fifo.sv
// Circular entry store for the writeback queue: pointers, occupancy and a
// one-edge lookahead of the head entry so the drain port can be registered.
module wb_entry_fifo
    import wb_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  wb_entry_t        push_entry_i,
    output wb_entry_t        mem_o [DEPTH],
    output logic [PTR_W-1:0] head_o,
    output logic [CNT_W-1:0] count_o,
    output logic [CNT_W-1:0] count_nxt_o,
    output logic             full_o,
    output wb_entry_t        nxt_head_o
);

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s, do_pop_s;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign do_push_s = push_i && !full_o && !flush_i;
    assign do_pop_s  = pop_i && (count_q != {CNT_W{1'b0}}) && !flush_i;

    // Next pointer and occupancy values; flush returns everything to the origin.
    always_comb begin
        if (flush_i) begin
            head_d  = {PTR_W{1'b0}};
            tail_d  = {PTR_W{1'b0}};
            count_d = {CNT_W{1'b0}};
        end else begin
            head_d  = head_q + PTR_W'(do_pop_s);
            tail_d  = tail_q + PTR_W'(do_push_s);
            count_d = count_q + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
        end
    end

    // Head after this edge: the entry being pushed if the queue drains empty, else storage.
    always_comb begin
        if (count_q == CNT_W'(do_pop_s)) begin
            nxt_head_o = push_entry_i;
        end else begin
            nxt_head_o = mem_q[head_d];
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= {PTR_W{1'b0}};
            tail_q  <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are only meaningful inside the head..tail window.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[tail_q] <= push_entry_i;
        end
    end

    assign mem_o       = mem_q;
    assign head_o      = head_q;
    assign count_o     = count_q;
    assign count_nxt_o = count_d;

endmodule

// File: rtl/register_writeback_queue.sv
// Writeback queue draining one register write per cycle into the 8x8 register bank.
// Optional macro WB_FORWARD_EN forwards the youngest queued value onto the read buses.
module register_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8,
    parameter int NREGS  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [2:0]        wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              drain_en,
    input  logic              flush,
    output logic [DATA_W-1:0] i_bus,
    output logic [NREGS-1:0]  i_regmask,
    output logic              setter,
    output logic [NREGS-1:0]  pending,
    input  logic [NREGS-1:0]  rd_regmask_a,
    input  logic [NREGS-1:0]  rd_regmask_b,
    input  logic [DATA_W-1:0] bank_bus_a,
    input  logic [DATA_W-1:0] bank_bus_b,
    output logic [DATA_W-1:0] fwd_bus_a,
    output logic [DATA_W-1:0] fwd_bus_b
);
    import wb_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t         mem_s [DEPTH];
    wb_entry_t         nxt_head_s, push_entry_s;
    logic [PTR_W-1:0]  head_s;
    logic [CNT_W-1:0]  count_s, count_nxt_s;
    logic              full_s, push_s;
    logic              setter_q, setter_d;
    logic [NREGS-1:0]  regmask_q, regmask_d, pending_s;
    logic [DATA_W-1:0] bus_q, bus_d;

    assign wb_ready             = rst_n && !flush && !full_s;
    assign push_s               = wb_valid && wb_ready;
    assign push_entry_s.reg_idx = wb_reg;
    assign push_entry_s.data    = wb_data;

    wb_entry_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush),
        .push_i       (push_s),
        .pop_i        (setter_q),
        .push_entry_i (push_entry_s),
        .mem_o        (mem_s),
        .head_o       (head_s),
        .count_o      (count_s),
        .count_nxt_o  (count_nxt_s),
        .full_o       (full_s),
        .nxt_head_o   (nxt_head_s)
    );

    // The write port is registered: decide at this edge what the bank sees next cycle,
    // and pop that entry on the edge where the bank captures it.
    always_comb begin
        setter_d = !flush && drain_en && (count_nxt_s != {CNT_W{1'b0}});
        if (setter_d) begin
            regmask_d = onehot_reg(nxt_head_s.reg_idx);
            bus_d     = nxt_head_s.data;
        end else begin
            regmask_d = {NREGS{1'b0}};
            bus_d     = {DATA_W{1'b0}};
        end
    end

    // Bank write-port registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            setter_q  <= 1'b0;
            regmask_q <= {NREGS{1'b0}};
            bus_q     <= {DATA_W{1'b0}};
        end else begin
            setter_q  <= setter_d;
            regmask_q <= regmask_d;
            bus_q     <= bus_d;
        end
    end

    // Hazard mask over the valid window, taken from registered queue state only.
    always_comb begin
        pending_s = {NREGS{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count_s) begin
                pending_s = pending_s | onehot_reg(mem_s[head_s + PTR_W'(i)].reg_idx);
            end else begin
                pending_s = pending_s;
            end
        end
    end

`ifdef WB_FORWARD_EN
    // Walk oldest to youngest so the youngest matching entry wins; a draining head still counts.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx       = head_s;
        fwd_bus_a = bank_bus_a;
        fwd_bus_b = bank_bus_b;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_s + PTR_W'(i);
            if (CNT_W'(i) < count_s) begin
                if (rd_regmask_a[mem_s[idx].reg_idx]) begin
                    fwd_bus_a = mem_s[idx].data;
                end else begin
                    fwd_bus_a = fwd_bus_a;
                end
                if (rd_regmask_b[mem_s[idx].reg_idx]) begin
                    fwd_bus_b = mem_s[idx].data;
                end else begin
                    fwd_bus_b = fwd_bus_b;
                end
            end else begin
                fwd_bus_a = fwd_bus_a;
                fwd_bus_b = fwd_bus_b;
            end
        end
    end
`else
    logic unused_rd_s;
    assign unused_rd_s = ^{rd_regmask_a, rd_regmask_b};
    assign fwd_bus_a   = bank_bus_a;
    assign fwd_bus_b   = bank_bus_b;
`endif

    assign setter    = setter_q;
    assign i_regmask = regmask_q;
    assign i_bus     = bus_q;
    assign pending   = pending_s;

endmodule

// File: tb/tb_register_writeback_queue.sv
// Self-checking bench for register_writeback_queue: directed plan steps plus random traffic
// compared against a queue-based reference model.
module tb_register_writeback_queue;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n, wb_valid, wb_ready, drain_en, flush, setter;
    logic [2:0] wb_reg;
    logic [7:0] wb_data, i_bus, i_regmask, pending;
    logic [7:0] rd_regmask_a, rd_regmask_b, bank_bus_a, bank_bus_b, fwd_bus_a, fwd_bus_b;

    always #5 clk = ~clk;

    register_writeback_queue #(.DEPTH(DEPTH), .DATA_W(8), .NREGS(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_reg       (wb_reg),
        .wb_data      (wb_data),
        .drain_en     (drain_en),
        .flush        (flush),
        .i_bus        (i_bus),
        .i_regmask    (i_regmask),
        .setter       (setter),
        .pending      (pending),
        .rd_regmask_a (rd_regmask_a),
        .rd_regmask_b (rd_regmask_b),
        .bank_bus_a   (bank_bus_a),
        .bank_bus_b   (bank_bus_b),
        .fwd_bus_a    (fwd_bus_a),
        .fwd_bus_b    (fwd_bus_b)
    );

    typedef struct {
        logic [2:0] r;
        logic [7:0] d;
    } ent_t;

    ent_t mq[$];
    int   vectors     = 0;
    int   miscompares = 0;
    logic exp_setter  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_pending();
        logic [7:0] m;
        m = 8'h00;
        foreach (mq[i]) m[mq[i].r] = 1'b1;
        return m;
    endfunction

    function automatic logic [7:0] model_fwd(input logic [7:0] rd, input logic [7:0] bank);
        logic [7:0] v;
        v = bank;
`ifdef WB_FORWARD_EN
        foreach (mq[i]) if (rd[mq[i].r]) v = mq[i].d;
`endif
        return v;
    endfunction

    // Registered bank-port and pending expectations, checked just after the edge.
    task automatic check_regs();
        logic [7:0] exp_mask, exp_bus;
        exp_mask = 8'h00;
        exp_bus  = 8'h00;
        if (exp_setter) begin
            exp_mask[mq[0].r] = 1'b1;
            exp_bus           = mq[0].d;
        end
        check("setter",    32'(setter),    32'(exp_setter));
        check("i_regmask", 32'(i_regmask), 32'(exp_mask));
        check("i_bus",     32'(i_bus),     32'(exp_bus));
        check("pending",   32'(pending),   32'(model_pending()));
    endtask

    // One clock cycle: drive, check combinational outputs mid-cycle, advance model, check registers.
    task automatic cycle(input logic v, input logic [2:0] r, input logic [7:0] d,
                         input logic de, input logic fl);
        logic exp_ready;
        ent_t e;
        wb_valid = v;
        wb_reg   = r;
        wb_data  = d;
        drain_en = de;
        flush    = fl;
        #4;
        exp_ready = !fl && (mq.size() != DEPTH);
        check("wb_ready",  32'(wb_ready),  32'(exp_ready));
        check("fwd_bus_a", 32'(fwd_bus_a), 32'(model_fwd(rd_regmask_a, bank_bus_a)));
        check("fwd_bus_b", 32'(fwd_bus_b), 32'(model_fwd(rd_regmask_b, bank_bus_b)));
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            if (exp_setter) void'(mq.pop_front());
            if (v && exp_ready) begin
                e.r = r;
                e.d = d;
                mq.push_back(e);
            end
        end
        exp_setter = !fl && de && (mq.size() != 0);
        #1;
        check_regs();
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        wb_valid = 1'b1;
        drain_en = 1'b1;
        flush    = 1'b0;
        #4;
        check("wb_ready_in_reset", 32'(wb_ready), 32'h0);
        @(posedge clk);
        mq.delete();
        exp_setter = 1'b0;
        #1;
        check_regs();
        rst_n    = 1'b1;
        wb_valid = 1'b0;
    endtask

    initial begin
        int k;
        rst_n        = 1'b0;
        wb_valid     = 1'b0;
        wb_reg       = 3'd0;
        wb_data      = 8'h00;
        drain_en     = 1'b0;
        flush        = 1'b0;
        rd_regmask_a = 8'h00;
        rd_regmask_b = 8'h00;
        bank_bus_a   = 8'h00;
        bank_bus_b   = 8'h00;
        @(posedge clk);
        #1;
        apply_reset();

        // Single write reaches the bank the cycle after acceptance.
        cycle(1'b1, 3'd3, 8'hA5, 1'b1, 1'b0);
        cycle(1'b0, 3'd0, 8'h00, 1'b1, 1'b0);

        // Fill with drain held, then a refused push, then drain in FIFO order.
        cycle(1'b1, 3'd0, 8'h10, 1'b0, 1'b0);
        cycle(1'b1, 3'd1, 8'h21, 1'b0, 1'b0);
        cycle(1'b1, 3'd2, 8'h32, 1'b0, 1'b0);
        cycle(1'b1, 3'd7, 8'h47, 1'b0, 1'b0);
        cycle(1'b1, 3'd4, 8'hEE, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 3'd0, 8'h00, 1'b1, 1'b0);

        // Full queue with a pop does not open a push slot; then sustained push+pop wraps.
        cycle(1'b1, 3'd1, 8'h51, 1'b0, 1'b0);
        cycle(1'b1, 3'd2, 8'h52, 1'b0, 1'b0);
        cycle(1'b1, 3'd3, 8'h53, 1'b0, 1'b0);
        cycle(1'b1, 3'd4, 8'h54, 1'b1, 1'b0);
        cycle(1'b1, 3'd5, 8'h55, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 3'(i), 8'(8'h60 + i), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 3'd0, 8'h00, 1'b1, 1'b0);

        // Flush during a push discards everything, including the new request.
        cycle(1'b1, 3'd2, 8'h11, 1'b0, 1'b0);
        cycle(1'b1, 3'd2, 8'h22, 1'b0, 1'b0);
        cycle(1'b1, 3'd6, 8'h99, 1'b0, 1'b1);
        cycle(1'b0, 3'd0, 8'h00, 1'b1, 1'b0);

        // Forwarding picks the youngest match; non-matching read falls back to the bank.
        cycle(1'b1, 3'd5, 8'h3C, 1'b0, 1'b0);
        cycle(1'b1, 3'd5, 8'h4D, 1'b0, 1'b0);
        rd_regmask_a = 8'h20;
        bank_bus_a   = 8'h00;
        rd_regmask_b = 8'h01;
        bank_bus_b   = 8'h5A;
        cycle(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        cycle(1'b1, 3'd6, 8'h77, 1'b1, 1'b0);

        // Reset while three entries are queued and draining.
        apply_reset();
        cycle(1'b1, 3'd4, 8'hC3, 1'b1, 1'b0);
        cycle(1'b0, 3'd0, 8'h00, 1'b1, 1'b0);

        // Random traffic with varying drain pressure and occasional flushes.
        for (int i = 0; i < 300; i++) begin
            k = $urandom_range(0, 8);
            rd_regmask_a = (k == 8) ? 8'h00 : 8'(1 << k);
            k = $urandom_range(0, 8);
            rd_regmask_b = (k == 8) ? 8'h00 : 8'(1 << k);
            bank_bus_a   = 8'($urandom_range(0, 255));
            bank_bus_b   = 8'($urandom_range(0, 255));
            cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                  $urandom_range(0, 99) < ((i < 150) ? 40 : 85), $urandom_range(0, 19) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/register_writeback_queue.md
# register_writeback_queue

Buffers register-file writeback requests from the execute/memory stages and drains them one per cycle into the 8×8-bit register bank. It drives that bank's `i_bus`, `i_regmask` and `setter` write port. It publishes a per-register pending mask so the issue logic can detect read-after-write hazards. It optionally forwards queued data onto the bank's two read buses.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, minimum 2.
- `DATA_W`, 8: data width; must match the register bank.
- `NREGS`, 8: register count; the register index is clog2(NREGS) = 3 bits.

Ports:
- `clk`  in  1  sole clock; all state updates on posedge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on posedge `clk`.
- `wb_valid`  in  1  upstream request valid.
- `wb_ready`  out  1  queue can accept a request.
- `wb_reg`  in  3  destination register index (binary).
- `wb_data`  in  DATA_W  value to write.
- `drain_en`  in  1  permits a drain this cycle; 0 holds the head.
- `flush`  in  1  discard all queued entries.
- `i_bus`  out  DATA_W  write data to the bank.
- `i_regmask`  out  NREGS  one-hot write mask to the bank.
- `setter`  out  1  bank write strobe.
- `pending`  out  NREGS  bit r = 1 while any queued entry targets register r.
- `rd_regmask_a` / `rd_regmask_b`  in  NREGS  one-hot read masks, as presented to the bank.
- `bank_bus_a` / `bank_bus_b`  in  DATA_W  bank read data.
- `fwd_bus_a` / `fwd_bus_b`  out  DATA_W  operand data for the consumer.

## Operation
- Circular FIFO: head pointer, tail pointer, count 0..DEPTH. Entry = {reg[2:0], data}.
- Push when `wb_valid && wb_ready`. `wb_ready = (count != DEPTH) && !flush`. When full, a simultaneous pop does not open a push slot.
- Drain when `count != 0 && drain_en && !flush`:
  - `setter` = 1.
  - `i_regmask` = one-hot(head.reg).
  - `i_bus` = head.data.
  - The head pops on the same posedge that the bank captures the write.
- When not draining, `setter` = 0, `i_regmask` = 0 and `i_bus` = 0. Stray writes to the bank are therefore impossible.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- `pending` is the OR of one-hot(reg) over all valid entries, derived from registered state only.
- `flush` takes priority over push, pop and drain. At the next edge, count = 0, head = tail = 0 and `pending` = 0. Entries already committed to the bank are not undone.
- Reset, the same edge `rst_n` is sampled low:
  - count = 0 and pointers = 0.
  - `setter`, `i_regmask`, `i_bus` and `pending` = 0.
  - `wb_ready` = 0 while `rst_n` is low, and 1 on the first cycle after release.
  - Reset mid-drain discards all entries.

## Timing
- Request accepted at edge N with the queue empty: `setter` high in cycle N+1, bank updated at edge N+1 (when `drain_en` = 1).
- Throughput is 1 write per cycle sustained.
- All outputs except `fwd_bus_*` and `wb_ready` come from registered state; there is no combinational path from inputs to them.
- `wb_ready` depends combinationally on `flush`.
- `fwd_bus_*` is combinational from `rd_regmask_*`, `bank_bus_*` and queue state.

## Configuration
- `WB_FORWARD_EN` defined:
  - `fwd_bus_x` = data of the youngest valid entry whose reg bit is set in `rd_regmask_x`.
  - If no entry matches, `fwd_bus_x` = `bank_bus_x`.
  - A head entry that is draining this cycle still forwards.
- `WB_FORWARD_EN` undefined: `fwd_bus_x = bank_bus_x`. The ports remain, and the issue logic stalls on `pending`.

## Structure
- Package `wb_pkg`:
  - `NREGS`, `DATA_W`, `REG_IDX_W` constants.
  - `wb_entry_t` struct.
  - `onehot_reg()` function.
- Sub-module `wb_entry_fifo`: storage, pointers, count, full/empty. Parent keeps the drain, pending and forwarding logic.

## Test plan
- Reset, then push reg 3 = 0xA5 with `drain_en` = 1 → next cycle `setter` = 1, `i_regmask` = 0x08, `i_bus` = 0xA5; `pending` = 0x08 for one cycle, then 0.
- `drain_en` = 0, push 4 entries (regs 0,1,2,7) → `wb_ready` = 0 and `pending` = 0x87. Enable drain → 4 writes in FIFO order over 4 cycles.
- Queue full with push and pop in the same cycle → push refused, count 3 afterwards. Run 10 push+pop cycles → pointers wrap and data order is preserved.
- Queue holds reg 2 twice (0x11 then 0x22), `drain_en` = 0, assert `flush` during a push → next cycle count = 0, `pending` = 0, the pushed entry is lost, and no `setter` pulse occurs.
- `WB_FORWARD_EN`: queued reg 5 = 0x3C and 0x4D, `rd_regmask_a` = 0x20, `bank_bus_a` = 0x00 → `fwd_bus_a` = 0x4D. With `rd_regmask_b` = 0x01 → `fwd_bus_b` = `bank_bus_b`.
- Assert `rst_n` low while 3 entries are queued and draining → at the next edge all outputs are 0. After release, the first push drains normally.
